// File: rtl/snn_pkg.sv
// Shared SNN definitions: default neuron widths and saturating unsigned arithmetic
// used by the neuron variants. Helpers work on a wide operand; callers zero-extend.
package snn_pkg;

  localparam int DEF_DATA_WIDTH      = 16;
  localparam int DEF_WEIGHT_WIDTH    = 8;
  localparam int DEF_THRESHOLD_WIDTH = 16;
  localparam int DEF_LEAK_WIDTH      = 8;
  localparam int DEF_REFRAC_WIDTH    = 8;

  // Operand width of the saturating helpers; neuron widths must stay below it.
  localparam int SAT_W = 32;
  typedef logic [SAT_W-1:0] sat_t;

  function automatic sat_t sat_add_u(input sat_t a, input sat_t b, input sat_t max_v);
    logic [SAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_v}) ? max_v : s[SAT_W-1:0];
  endfunction

  function automatic sat_t sat_sub_u(input sat_t a, input sat_t b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: linear leak, saturating synaptic integration,
// one-cycle registered spike and programmable refractory window.
module lif_neuron_core
  import snn_pkg::*;
#(
  parameter int NEURON_ID       = 0,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH    = DEF_WEIGHT_WIDTH,
  parameter int THRESHOLD_WIDTH = DEF_THRESHOLD_WIDTH,
  parameter int LEAK_WIDTH      = DEF_LEAK_WIDTH,
  parameter int REFRAC_WIDTH    = DEF_REFRAC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       syn_valid,
  input  logic [WEIGHT_WIDTH-1:0]    syn_weight,
  input  logic                       syn_excitatory,
  input  logic [THRESHOLD_WIDTH-1:0] threshold,
  input  logic [LEAK_WIDTH-1:0]      leak_rate,
  input  logic [REFRAC_WIDTH-1:0]    refractory_period,
  input  logic                       reset_potential_en,
  input  logic [DATA_WIDTH-1:0]      reset_potential,
  output logic                       spike_out,
  output logic [DATA_WIDTH-1:0]      membrane_potential,
  output logic                       is_refractory,
  output logic [REFRAC_WIDTH-1:0]    refrac_count
);

  if (NEURON_ID < 0 || THRESHOLD_WIDTH != DATA_WIDTH || DATA_WIDTH >= SAT_W ||
      WEIGHT_WIDTH > DATA_WIDTH || LEAK_WIDTH > DATA_WIDTH) begin : g_bad_cfg
    $error("lif_neuron_core: unsupported width configuration");
  end

  localparam sat_t VMAX = SAT_W'({DATA_WIDTH{1'b1}});

  sat_t v1, v2;
  logic fire;

  // Leak first, then the synaptic event, both clamped to the unsigned range.
  always_comb begin
    v1 = sat_sub_u(SAT_W'(membrane_potential), SAT_W'(leak_rate));
    v2 = v1;
    if (syn_valid)
      v2 = syn_excitatory ? sat_add_u(v1, SAT_W'(syn_weight), VMAX)
                          : sat_sub_u(v1, SAT_W'(syn_weight));
    fire = (threshold != '0) && (v2 >= SAT_W'(threshold));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      membrane_potential <= '0;
      refrac_count       <= '0;
      spike_out          <= 1'b0;
    end else if (!enable) begin
      spike_out <= 1'b0;
    end else if (refrac_count != '0) begin
      refrac_count <= refrac_count - REFRAC_WIDTH'(1);
      spike_out    <= 1'b0;
    end else if (fire) begin
      membrane_potential <= reset_potential_en ? reset_potential : '0;
      refrac_count       <= refractory_period;
      spike_out          <= 1'b1;
    end else begin
      membrane_potential <= DATA_WIDTH'(v2);
      spike_out          <= 1'b0;
    end
  end

  assign is_refractory = (refrac_count != '0);

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed plus randomized checks of lif_neuron_core against an integer reference model.
module tb_lif_neuron_core;

  logic        clk = 1'b0;
  logic        rst, enable, syn_valid, syn_excitatory, reset_potential_en;
  logic [7:0]  syn_weight, leak_rate, refractory_period;
  logic [15:0] threshold, reset_potential;
  logic        spike_out, is_refractory;
  logic [15:0] membrane_potential;
  logic [7:0]  refrac_count;

  lif_neuron_core #(.NEURON_ID(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .syn_valid(syn_valid),
    .syn_weight(syn_weight), .syn_excitatory(syn_excitatory),
    .threshold(threshold), .leak_rate(leak_rate),
    .refractory_period(refractory_period),
    .reset_potential_en(reset_potential_en), .reset_potential(reset_potential),
    .spike_out(spike_out), .membrane_potential(membrane_potential),
    .is_refractory(is_refractory), .refrac_count(refrac_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, fail_cnt = 0, total = 0, cyc = 0;
  int m_v = 0, m_rc = 0, m_sp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference behaviour of one clock edge, in plain integer arithmetic.
  task automatic model_step();
    int v;
    if (rst) begin
      m_v = 0; m_rc = 0; m_sp = 0;
    end else if (!enable) begin
      m_sp = 0;
    end else if (m_rc > 0) begin
      m_rc = m_rc - 1; m_sp = 0;
    end else begin
      v = m_v - int'(leak_rate);
      if (v < 0) v = 0;
      if (syn_valid) begin
        v = syn_excitatory ? v + int'(syn_weight) : v - int'(syn_weight);
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
      end
      if (threshold != 0 && v >= int'(threshold)) begin
        m_sp = 1;
        m_v  = reset_potential_en ? int'(reset_potential) : 0;
        m_rc = int'(refractory_period);
      end else begin
        m_sp = 0; m_v = v;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk($sformatf("mem@%0d", cyc), 32'(membrane_potential), 32'(m_v));
    chk($sformatf("spike@%0d", cyc), 32'(spike_out), 32'(m_sp));
    chk($sformatf("rc@%0d", cyc), 32'(refrac_count), 32'(m_rc));
    chk($sformatf("isref@%0d", cyc), 32'(is_refractory), 32'(m_rc != 0));
  endtask

  task automatic ev(input logic [7:0] w, input logic exc);
    syn_valid = 1'b1; syn_weight = w; syn_excitatory = exc;
    cycle();
    syn_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cycle(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; syn_valid = 1'b0; syn_excitatory = 1'b1;
    syn_weight = '0; leak_rate = '0; refractory_period = '0; threshold = '0;
    reset_potential_en = 1'b0; reset_potential = '0;

    // Reset state
    cycle(); cycle(); rst = 1'b0;
    chk("rst_mem", 32'(membrane_potential), 0);
    chk("rst_spike", 32'(spike_out), 0);
    chk("rst_rc", 32'(refrac_count), 0);
    chk("rst_isref", 32'(is_refractory), 0);

    // Integrate and fire, then events dropped during refractory
    threshold = 16'h0040; leak_rate = 0; refractory_period = 5;
    ev(8'h20, 1'b1);
    chk("if_mem1", 32'(membrane_potential), 32'h20);
    ev(8'h20, 1'b1);
    chk("if_spike", 32'(spike_out), 1);
    chk("if_mem_reset", 32'(membrane_potential), 0);
    chk("if_rc5", 32'(refrac_count), 5);
    for (int i = 4; i >= 0; i--) begin
      ev(8'h20, 1'b1);
      chk($sformatf("refr_rc%0d", i), 32'(refrac_count), 32'(i));
      chk("refr_mem", 32'(membrane_potential), 0);
      chk("refr_nospike", 32'(spike_out), 0);
    end
    ev(8'h20, 1'b1);
    chk("refr_first_after", 32'(membrane_potential), 32'h20);

    // Leak to zero without wrapping
    do_reset();
    threshold = 16'h1000; leak_rate = 2;
    ev(8'h20, 1'b1);
    chk("leak_start", 32'(membrane_potential), 32'h20);
    for (int i = 1; i < 22; i++) begin
      cycle();
      chk($sformatf("leak_%0d", i), 32'(membrane_potential),
          32'((32 - 2 * i) > 0 ? (32 - 2 * i) : 0));
    end

    // Inhibitory floor, excitatory saturation
    do_reset();
    leak_rate = 0;
    ev(8'h10, 1'b1);
    chk("inh_pre", 32'(membrane_potential), 32'h10);
    ev(8'h20, 1'b0);
    chk("inh_floor", 32'(membrane_potential), 0);
    threshold = 0;
    for (int i = 0; i < 260; i++) ev(8'hFF, 1'b1);
    chk("sat_max", 32'(membrane_potential), 32'hFFFF);
    ev(8'hFF, 1'b1);
    chk("sat_hold", 32'(membrane_potential), 32'hFFFF);
    chk("sat_nospike", 32'(spike_out), 0);

    // Reset potential, then frozen while disabled
    do_reset();
    threshold = 16'h0040; refractory_period = 3;
    reset_potential_en = 1'b1; reset_potential = 16'h0010;
    ev(8'h40, 1'b1);
    chk("rp_spike", 32'(spike_out), 1);
    chk("rp_mem", 32'(membrane_potential), 32'h10);
    enable = 1'b0; syn_valid = 1'b1; syn_weight = 8'h20;
    for (int i = 0; i < 10; i++) cycle();
    syn_valid = 1'b0;
    chk("dis_mem", 32'(membrane_potential), 32'h10);
    chk("dis_rc", 32'(refrac_count), 3);
    chk("dis_spike", 32'(spike_out), 0);

    // Reset mid-refractory (refrac_count = 3)
    enable = 1'b1;
    do_reset();
    chk("rstref_mem", 32'(membrane_potential), 0);
    chk("rstref_rc", 32'(refrac_count), 0);
    chk("rstref_isref", 32'(is_refractory), 0);
    chk("rstref_spike", 32'(spike_out), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst                = ($urandom_range(0, 99) < 2);
      enable             = ($urandom_range(0, 9) != 0);
      syn_valid          = ($urandom_range(0, 9) < 6);
      syn_excitatory     = ($urandom_range(0, 9) < 7);
      syn_weight         = 8'($urandom);
      threshold          = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h180));
      leak_rate          = 8'($urandom_range(0, 4));
      refractory_period  = 8'($urandom_range(0, 4));
      reset_potential_en = 1'($urandom);
      reset_potential    = 16'($urandom_range(0, 16'h30));
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
